aes_decipher_block_par: RTL and testbench
=========================================

Name: aes_decipher_block_par

Overview:
Iterative AES inverse-cipher datapath with a selectable key length of 128, 192 or 256 bits. The number of InvSubBytes words processed per cycle is set by a parameter, which trades inverse S-box area against latency. It sits between the top-level AES core control and the key memory, which combinationally supplies round_key for the round index driven on the round output. The block performs the initial, main and final inverse rounds under a next/ready handshake.

Parameters:
NUM_SBOX, 1, number of 32-bit inverse S-box words per cycle; legal values 1, 2, 4; any other value is an elaboration error.
SBOX_CYCLES, 4/NUM_SBOX, derived localparam; InvSubBytes cycles per round (S below).

Ports:
clk  in  1  system clock
reset_n  in  1  reset
next  in  1  start pulse; sampled only in IDLE
keylen  in  2  00=AES-128 (NR=10), 01=AES-192 (NR=12), 10=AES-256 (NR=14), 11=reserved, treated as NR=14
round  out  4  current round-key index requested from key memory
round_key  in  128  round key for index round, valid in the same cycle
block  in  128  ciphertext; sampled in the INIT cycle
new_block  out  128  state register; plaintext when ready=1 after an operation
ready  out  1  1=idle/result valid, 0=busy
Interface note: one clock; reset is synchronous and active-low.

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE, ready=1, round=0, new_block=0, sword counter=0. Reset applied mid-operation aborts the operation in the same edge; no partial result is retained.
- The state word is held as 4 x 32-bit registers w0..w3 (w0 = bits 127:96), each with its own write enable.
- IDLE:
  - next=1: round <= NR (from keylen, sampled this edge only), ready <= 0, go to INIT.
  - next=0: hold.
- INIT (1 cycle): state <= InvShiftRows(block ^ round_key); sword counter <= 0; go to SBOX.
- SBOX (S cycles):
  - Each cycle, words [c*NUM_SBOX .. c*NUM_SBOX+NUM_SBOX-1] pass through NUM_SBOX inverse S-boxes; only those words are written.
  - On the last cycle (c = S-1): round <= round-1; go to MAIN.
  - Counter width is max(1, log2(S)) bits. For NUM_SBOX=4 the counter is tied to 0 and each SBOX phase is exactly one cycle.
- MAIN (1 cycle), sword counter <= 0:
  - round>0: state <= InvShiftRows(InvMixColumns(state ^ round_key)); go to SBOX.
  - round==0: state <= state ^ round_key (final); ready <= 1; go to IDLE.
- Latency: ready rises at edge 1 + NR*(S+1) counted after the accepting IDLE edge.
  - NUM_SBOX=1: 51/61/71 cycles for NR=10/12/14.
  - NUM_SBOX=4: 21/25/29 cycles.
- next while busy: ignored, no queuing. next in the same cycle ready rises: ignored, because the FSM is not yet in IDLE.
- keylen and block may change while busy without effect, except that block is sampled in INIT only.
- new_block is stable from ready rising until the next INIT edge.
- round never underflows; it is 0 only in the final MAIN cycle and in IDLE after completion.
- InvMixColumns uses GF(2^8) with polynomial 0x11b; coefficients 0e, 0b, 0d, 09 per column.
- Unused state encodings return to IDLE on the next edge with ready=1.

Optional Feature:
AES_DEC_ABORT_EN:
- Defined: adds input port abort (1 bit). abort=1 in any non-IDLE state sends the FSM to IDLE at the next edge with ready=1, round=0 and new_block zeroed, so no partial plaintext is exposed. abort has priority over every other transition. abort in IDLE clears new_block to 0.
- Undefined: the port does not exist; an operation always runs to completion unless reset.

Test Plan:
1. AES-128, NUM_SBOX=1, FIPS-197 C.1 (key 000102..0f), block=69c4e0d86a7b0430d8cdb78070b4c55a, bench key model drives round_key -> new_block=00112233445566778899aabbccddeeff; ready low exactly 51 cycles.
2. AES-192 C.2, block=dda97ca4864cdfe06eaf70a0ec0d7191 -> 00112233445566778899aabbccddeeff; 61 cycles (NUM_SBOX=1), 25 cycles (NUM_SBOX=4); round sequence 12,11,...,0 observed.
3. AES-256 C.3, block=8ea2b7ca516745bfeafc49904b496089, repeated with NUM_SBOX=1, 2, 4 -> same plaintext in each case; 71/43/29 cycles respectively.
4. Pulse next at cycles 5 and 20 of a running AES-128 operation, and again on the cycle ready rises -> a single result, no restart; a fresh next one cycle later starts a new operation.
5. Assert reset_n=0 for 1 cycle at cycle 30 of an AES-256 operation -> next edge shows ready=1, round=0, new_block=0; a following C.1 vector decrypts correctly.
6. With AES_DEC_ABORT_EN: abort at cycle 10 -> ready=1 and new_block=0 next edge; a subsequent C.3 decrypt is correct. Without the macro, a compile with no abort port passes.

Source files
------------

// File: rtl/aes_decipher_block_par.sv
// Iterative AES inverse cipher (AES-128/192/256) with NUM_SBOX inverse S-box words per cycle.
// Define AES_DEC_ABORT_EN to add an abort input that cancels a running operation.
module aes_decipher_block_par #(
    parameter int unsigned NUM_SBOX = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
`ifdef AES_DEC_ABORT_EN
    input  logic         abort,
`endif
    input  logic [1:0]   keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    localparam int unsigned SBOX_CYCLES = 4 / NUM_SBOX;
    localparam int unsigned CNT_W       = (SBOX_CYCLES > 1) ? $clog2(SBOX_CYCLES) : 1;

    if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_bad_num_sbox
        $error("aes_decipher_block_par: NUM_SBOX must be 1, 2 or 4");
    end

    // GF(2^8) arithmetic over x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = gf_xt(x);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Inverse S-box: undo the affine map, then invert in the field
    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] z;
        z = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gf_inv(z);
    endfunction

    function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
        return {inv_sbox(w[31:24]), inv_sbox(w[23:16]), inv_sbox(w[15:8]), inv_sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {inv_mix_column(s[127:96]), inv_mix_column(s[95:64]),
                inv_mix_column(s[63:32]),  inv_mix_column(s[31:0])};
    endfunction

    // Row r of the state rotates right by r columns
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int b = 0; b < 4; b++) begin
                r[127 - 32*c - 8*b -: 8] = s[127 - 32*((c - b + 4) % 4) - 8*b -: 8];
            end
        end
        return r;
    endfunction

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        SBOX = 3'd2,
        MAIN = 3'd3
    } state_t;

    state_t           state;
    state_t           state_new;
    logic [31:0]      w     [4];
    logic [31:0]      w_new [4];
    logic [3:0]       w_we;
    logic [3:0]       round_new;
    logic             round_we;
    logic             ready_new;
    logic             ready_we;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_new;
    logic             cnt_we;
    logic [3:0]       key_nr;
    logic             abort_req;
    logic [127:0]     state_vec;
    logic [127:0]     init_vec;
    logic [127:0]     main_vec;
    logic [127:0]     final_vec;
    logic [1:0]       lane_idx [NUM_SBOX];
    logic [31:0]      lane_out [NUM_SBOX];

`ifdef AES_DEC_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        case (keylen)
            2'b00:   key_nr = 4'd10;
            2'b01:   key_nr = 4'd12;
            default: key_nr = 4'd14;
        endcase
    end

    assign state_vec = {w[0], w[1], w[2], w[3]};
    assign new_block = state_vec;
    assign init_vec  = inv_shift_rows(block ^ round_key);
    assign main_vec  = inv_shift_rows(inv_mix_columns(state_vec ^ round_key));
    assign final_vec = state_vec ^ round_key;

    // Each lane serves word cnt*NUM_SBOX + j during the SBOX phase
    for (genvar j = 0; j < NUM_SBOX; j++) begin : g_lane
        assign lane_idx[j] = 2'(32'(cnt) * NUM_SBOX + 32'(j));
        assign lane_out[j] = inv_sub_word(w[lane_idx[j]]);
    end

    always_comb begin
        state_new = state;
        for (int i = 0; i < 4; i++) w_new[i] = w[i];
        w_we      = 4'b0000;
        round_new = round;
        round_we  = 1'b0;
        ready_new = ready;
        ready_we  = 1'b0;
        cnt_new   = cnt;
        cnt_we    = 1'b0;

        if (abort_req) begin
            state_new = IDLE;
            ready_new = 1'b1;
            ready_we  = 1'b1;
            round_new = 4'd0;
            round_we  = 1'b1;
            for (int i = 0; i < 4; i++) w_new[i] = 32'h0;
            w_we      = 4'b1111;
            cnt_new   = '0;
            cnt_we    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (next) begin
                        round_new = key_nr;
                        round_we  = 1'b1;
                        ready_new = 1'b0;
                        ready_we  = 1'b1;
                        state_new = INIT;
                    end
                end
                INIT: begin
                    {w_new[0], w_new[1], w_new[2], w_new[3]} = init_vec;
                    w_we      = 4'b1111;
                    cnt_new   = '0;
                    cnt_we    = 1'b1;
                    state_new = SBOX;
                end
                SBOX: begin
                    for (int j = 0; j < NUM_SBOX; j++) begin
                        w_new[lane_idx[j]] = lane_out[j];
                        w_we[lane_idx[j]]  = 1'b1;
                    end
                    if (cnt == CNT_W'(SBOX_CYCLES - 1)) begin
                        round_new = round - 4'd1;
                        round_we  = 1'b1;
                        state_new = MAIN;
                    end else begin
                        cnt_new = (SBOX_CYCLES == 1) ? '0 : cnt + CNT_W'(1);
                        cnt_we  = 1'b1;
                    end
                end
                MAIN: begin
                    cnt_new = '0;
                    cnt_we  = 1'b1;
                    w_we    = 4'b1111;
                    if (round != 4'd0) begin
                        {w_new[0], w_new[1], w_new[2], w_new[3]} = main_vec;
                        state_new = SBOX;
                    end else begin
                        {w_new[0], w_new[1], w_new[2], w_new[3]} = final_vec;
                        ready_new = 1'b1;
                        ready_we  = 1'b1;
                        state_new = IDLE;
                    end
                end
                default: begin
                    ready_new = 1'b1;
                    ready_we  = 1'b1;
                    state_new = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_new;
    end

    // Datapath and control registers; reset discards any partial result
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ready <= 1'b1;
            round <= 4'd0;
            cnt   <= '0;
            for (int i = 0; i < 4; i++) w[i] <= 32'h0;
        end else begin
            if (ready_we) ready <= ready_new;
            if (round_we) round <= round_new;
            if (cnt_we)   cnt   <= cnt_new;
            for (int i = 0; i < 4; i++) begin
                if (w_we[i]) w[i] <= w_new[i];
            end
        end
    end

endmodule

// File: tb/tb_aes_decipher_block_par.sv
// Directed bench for aes_decipher_block_par: FIPS-197 vectors on NUM_SBOX = 1, 2 and 4 instances.
module tb_aes_decipher_block_par;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] K1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K2  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic         clk;
    logic         reset_n;
    logic         next1, next2, next4;
    logic [1:0]   keylen;
    logic [127:0] block;
    logic [3:0]   round1, round2, round4;
    logic [127:0] round_key1, round_key2, round_key4;
    logic [127:0] new_block1, new_block2, new_block4;
    logic         ready1, ready2, ready4;
`ifdef AES_DEC_ABORT_EN
    logic         abort;
`endif

    logic [127:0] rk [16];
    logic [3:0]   seq1 [$];
    int           vectors;
    int           miscompares;

    assign round_key1 = rk[round1];
    assign round_key2 = rk[round2];
    assign round_key4 = rk[round4];

    aes_decipher_block_par #(.NUM_SBOX(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .next(next1),
`ifdef AES_DEC_ABORT_EN
        .abort(abort),
`endif
        .keylen(keylen), .round(round1), .round_key(round_key1),
        .block(block), .new_block(new_block1), .ready(ready1)
    );

    aes_decipher_block_par #(.NUM_SBOX(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .next(next2),
`ifdef AES_DEC_ABORT_EN
        .abort(abort),
`endif
        .keylen(keylen), .round(round2), .round_key(round_key2),
        .block(block), .new_block(new_block2), .ready(ready2)
    );

    aes_decipher_block_par #(.NUM_SBOX(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .next(next4),
`ifdef AES_DEC_ABORT_EN
        .abort(abort),
`endif
        .keylen(keylen), .round(round4), .round_key(round_key4),
        .block(block), .new_block(new_block4), .ready(ready4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Key-memory model: forward S-box via brute-force field inverse plus affine map
    function automatic logic [7:0] b_xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] b_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = b_xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] b_sbox(input logic [7:0] x);
        logic [7:0] v;
        v = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (b_mul(x, 8'(y)) == 8'h01) v = 8'(y);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] b_sub_word(input logic [31:0] w);
        return {b_sbox(w[31:24]), b_sbox(w[23:16]), b_sbox(w[15:8]), b_sbox(w[7:0])};
    endfunction

    task automatic load_key(input logic [255:0] key, input int nk);
        logic [31:0] kw [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int          nr;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < 60; i++) kw[i] = 32'h0;
        for (int i = 0; i < nk; i++) kw[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = kw[i-1];
            if (i % nk == 0) begin
                t    = b_sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = b_xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = b_sub_word(t);
            end
            kw[i] = kw[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= nr) rk[r] = {kw[4*r], kw[4*r+1], kw[4*r+2], kw[4*r+3]};
            else         rk[r] = 128'h0;
        end
    endtask

    // Start all three instances together; record each ready-rise cycle and result
    task automatic run_op(input logic [1:0] kl, input logic [127:0] ct,
                          output int l1, output int l2, output int l4,
                          output logic [127:0] d1, output logic [127:0] d2, output logic [127:0] d4);
        l1 = 0; l2 = 0; l4 = 0;
        d1 = '0; d2 = '0; d4 = '0;
        keylen = kl;
        block  = ct;
        next1 = 1'b1; next2 = 1'b1; next4 = 1'b1;
        @(posedge clk); #1;
        next1 = 1'b0; next2 = 1'b0; next4 = 1'b0;
        seq1.delete();
        seq1.push_back(round1);
        for (int cyc = 1; cyc <= 150; cyc++) begin
            @(posedge clk); #1;
            if (round1 != seq1[$]) seq1.push_back(round1);
            if (ready1 && l1 == 0) begin l1 = cyc; d1 = new_block1; end
            if (ready2 && l2 == 0) begin l2 = cyc; d2 = new_block2; end
            if (ready4 && l4 == 0) begin l4 = cyc; d4 = new_block4; end
            if (l1 != 0 && l2 != 0 && l4 != 0) break;
        end
    endtask

    initial begin
        int           l1, l2, l4, rise1, rise2;
        logic [127:0] d1, d2, d4, dfirst, dsecond;
        logic         rdy52, rdy53;

        vectors     = 0;
        miscompares = 0;
        reset_n = 1'b0;
        next1 = 1'b0; next2 = 1'b0; next4 = 1'b0;
        keylen = 2'b00;
        block  = 128'h0;
`ifdef AES_DEC_ABORT_EN
        abort = 1'b0;
`endif
        for (int r = 0; r < 16; r++) rk[r] = 128'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready1", 128'(ready1), 128'd1);
        check("rst_round1", 128'(round1), 128'd0);
        check("rst_block1", new_block1, 128'h0);
        check("rst_ready2", 128'(ready2), 128'd1);
        check("rst_ready4", 128'(ready4), 128'd1);
        check("rst_block4", new_block4, 128'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // AES-128
        load_key(K1, 4);
        run_op(2'b00, CT1, l1, l2, l4, d1, d2, d4);
        check("c1_lat1", 128'(l1), 128'd51);
        check("c1_lat2", 128'(l2), 128'd31);
        check("c1_lat4", 128'(l4), 128'd21);
        check("c1_pt1", d1, PT);
        check("c1_pt2", d2, PT);
        check("c1_pt4", d4, PT);
        check("c1_hold4", new_block4, PT);

        // AES-192 plus the round-key index sequence
        load_key(K2, 6);
        run_op(2'b01, CT2, l1, l2, l4, d1, d2, d4);
        check("c2_lat1", 128'(l1), 128'd61);
        check("c2_lat2", 128'(l2), 128'd37);
        check("c2_lat4", 128'(l4), 128'd25);
        check("c2_pt1", d1, PT);
        check("c2_pt2", d2, PT);
        check("c2_pt4", d4, PT);
        check("c2_seq_len", 128'(seq1.size()), 128'd13);
        for (int i = 0; i < 13 && i < seq1.size(); i++) begin
            check($sformatf("c2_seq%0d", i), 128'(seq1[i]), 128'(12 - i));
        end

        // AES-256, then reserved keylen which also means 14 rounds
        load_key(K3, 8);
        run_op(2'b10, CT3, l1, l2, l4, d1, d2, d4);
        check("c3_lat1", 128'(l1), 128'd71);
        check("c3_lat2", 128'(l2), 128'd43);
        check("c3_lat4", 128'(l4), 128'd29);
        check("c3_pt1", d1, PT);
        check("c3_pt2", d2, PT);
        check("c3_pt4", d4, PT);
        run_op(2'b11, CT3, l1, l2, l4, d1, d2, d4);
        check("kl3_lat1", 128'(l1), 128'd71);
        check("kl3_pt1", d1, PT);
        check("kl3_pt4", d4, PT);

        // next while busy and on the ready-rise cycle is ignored
        load_key(K1, 4);
        keylen = 2'b00;
        block  = CT1;
        next1  = 1'b1;
        @(posedge clk); #1;
        next1 = 1'b0;
        rise1 = 0; rise2 = 0; rdy52 = 1'b0; rdy53 = 1'b1;
        dfirst = '0; dsecond = '0;
        for (int cyc = 1; cyc <= 130; cyc++) begin
            next1 = (cyc == 5 || cyc == 20 || cyc == 51 || cyc == 53);
            @(posedge clk); #1;
            if (cyc == 52) rdy52 = ready1;
            if (cyc == 53) rdy53 = ready1;
            if (ready1 && rise1 == 0) begin
                rise1 = cyc; dfirst = new_block1;
            end else if (cyc > 53 && ready1 && rise2 == 0) begin
                rise2 = cyc; dsecond = new_block1;
            end
            if (rise2 != 0) break;
        end
        next1 = 1'b0;
        check("busy_rise1", 128'(rise1), 128'd51);
        check("busy_pt1", dfirst, PT);
        check("busy_idle52", 128'(rdy52), 128'd1);
        check("busy_start53", 128'(rdy53), 128'd0);
        check("busy_rise2", 128'(rise2), 128'd104);
        check("busy_pt2", dsecond, PT);

        // Synchronous reset in the middle of an AES-256 operation
        load_key(K3, 8);
        keylen = 2'b10;
        block  = CT3;
        next1 = 1'b1; next2 = 1'b1; next4 = 1'b1;
        @(posedge clk); #1;
        next1 = 1'b0; next2 = 1'b0; next4 = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (cyc == 30) reset_n = 1'b0;
            @(posedge clk); #1;
        end
        reset_n = 1'b1;
        check("mrst_ready1", 128'(ready1), 128'd1);
        check("mrst_round1", 128'(round1), 128'd0);
        check("mrst_block1", new_block1, 128'h0);
        check("mrst_ready2", 128'(ready2), 128'd1);
        check("mrst_block2", new_block2, 128'h0);
        check("mrst_block4", new_block4, 128'h0);
        load_key(K1, 4);
        run_op(2'b00, CT1, l1, l2, l4, d1, d2, d4);
        check("mrst_c1_lat1", 128'(l1), 128'd51);
        check("mrst_c1_pt1", d1, PT);
        check("mrst_c1_pt2", d2, PT);
        check("mrst_c1_pt4", d4, PT);

`ifdef AES_DEC_ABORT_EN
        // Abort at cycle 10 hides the partial state
        load_key(K3, 8);
        keylen = 2'b10;
        block  = CT3;
        next1 = 1'b1; next2 = 1'b1; next4 = 1'b1;
        @(posedge clk); #1;
        next1 = 1'b0; next2 = 1'b0; next4 = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            abort = (cyc == 10);
            @(posedge clk); #1;
        end
        abort = 1'b0;
        check("abort_ready1", 128'(ready1), 128'd1);
        check("abort_round1", 128'(round1), 128'd0);
        check("abort_block1", new_block1, 128'h0);
        check("abort_ready4", 128'(ready4), 128'd1);
        check("abort_block4", new_block4, 128'h0);
        run_op(2'b10, CT3, l1, l2, l4, d1, d2, d4);
        check("abort_c3_lat1", 128'(l1), 128'd71);
        check("abort_c3_pt1", d1, PT);
        check("abort_c3_pt2", d2, PT);
        check("abort_c3_pt4", d4, PT);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
